io_hub: RTL and testbench

//   Parametrised memory-mapped IO block for the single-cycle CPU. It replaces the separate led/switch blocks
//   and the per-key erase_shake instances with one unit.
//   - Drives LED_WIDTH LEDs from software-written registers.
//   - Synchronises SW_WIDTH switches.
//   - Debounces NUM_KEYS push-buttons and latches each key's rising edge in a sticky flag.
//   - The sticky flag clears when software reads it.
//   The block sits behind MemOrIO on the 16-bit IO data path and is selected by io_sel.

---
 rtl/io_hub.sv | 178 +++++++++++++++++
 tb/tb_io_hub.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_hub.sv
// io_hub: memory-mapped IO block for the single-cycle CPU.
//   Drives LEDs from software-written registers and synchronises the switch
//   inputs. Each push-button is debounced, and a sticky flag records the
//   key's rising edge. The flags clear when software reads them.
// Ports:
//   clock, reset           system clock; asynchronous active-high reset
//   io_sel/io_read/io_write block select and strobes from MemOrIO
//   addr[3:0]              halfword offset (bit0 ignored)
//   wdata[15:0]            write data
//   rdata[15:0]            combinational read data, 0 when not read-selected
//   switches[SW_WIDTH]     raw switch pins
//   keys[NUM_KEYS]         raw active-high buttons
//   leds[LED_WIDTH]        registered LED drive
// Register map (halfword offsets):
//   0x0 LED lo, 0x2 LED hi, 0x4 SW lo, 0x6 SW hi,
//   0x8 key level, 0xA key flags (clear-on-read)

// One key channel: 2-flop synchroniser followed by the debounce FSM.
// rise is the decode of "level goes 0->1 on this edge". It lets the parent
// set the sticky flag on the same edge that level changes.
module io_hub_key #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise
);
    typedef enum logic {STABLE = 1'b0, COUNTING = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1, s2;

    assign rise = (state == COUNTING) && s2 && !level && (cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= STABLE;
            cnt   <= '0;
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            case (state)
                STABLE: begin
                    if (s2 != level) begin
                        state <= COUNTING;
                        cnt   <= CNT_W'(1);
                    end
                end
                COUNTING: begin
                    if (s2 == level) begin
                        // Input went back before the window elapsed: a glitch.
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        level <= s2;
                        state <= STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

module io_hub #(
    parameter int NUM_KEYS        = 2,
    parameter int SW_WIDTH        = 24,
    parameter int LED_WIDTH       = 24,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_sel,
    input  logic                 io_read,
    input  logic                 io_write,
    input  logic [3:0]           addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata,
    input  logic [SW_WIDTH-1:0]  switches,
    input  logic [NUM_KEYS-1:0]  keys,
    output logic [LED_WIDTH-1:0] leds
);
    logic                rd_en, wr_en, rd_flags;
    logic [2:0]          reg_idx;
    logic [SW_WIDTH-1:0] sw_s1, sw_s2;
    logic [NUM_KEYS-1:0] level, rise, flags;
    logic [31:0]         led_pad, sw_pad, led_nxt;
    logic [15:0]         level_pad, flag_pad;
    logic                unused_bits;

    assign reg_idx  = addr[3:1];
    // rdata must read 0 while reset is held, so reset also gates the read.
    assign rd_en    = io_sel & io_read & ~reset;
    assign wr_en    = io_sel & io_write;
    assign rd_flags = rd_en && (reg_idx == 3'd5);

    assign unused_bits = ^{addr[0], led_nxt};

    // Zero-extend every field to its full register width so the
    // unused high bits read as 0 for any parameter choice.
    always_comb begin
        led_pad   = '0;
        sw_pad    = '0;
        level_pad = '0;
        flag_pad  = '0;
        led_pad[LED_WIDTH-1:0] = leds;
        sw_pad[SW_WIDTH-1:0]   = sw_s2;
        level_pad[NUM_KEYS-1:0] = level;
        flag_pad[NUM_KEYS-1:0]  = flags;
    end

    // A write to the upper LED half is truncated away when LED_WIDTH <= 16.
    always_comb begin
        led_nxt = led_pad;
        if (wr_en && reg_idx == 3'd0) led_nxt[15:0]  = wdata;
        if (wr_en && reg_idx == 3'd1) led_nxt[31:16] = wdata;
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (reg_idx)
                3'd0:    rdata = led_pad[15:0];
                3'd1:    rdata = led_pad[31:16];
                3'd2:    rdata = sw_pad[15:0];
                3'd3:    rdata = sw_pad[31:16];
                3'd4:    rdata = level_pad;
                3'd5:    rdata = flag_pad;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leds  <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            flags <= '0;
        end else begin
            leds  <= led_nxt[LED_WIDTH-1:0];
            sw_s1 <= switches;
            sw_s2 <= sw_s1;
            // Every flag is returned by the read and so is cleared.
            // A rise on the same edge still sets its flag.
            flags <= (rd_flags ? '0 : flags) | rise;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        io_hub_key #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_key (
            .clock(clock),
            .reset(reset),
            .pin  (keys[k]),
            .level(level[k]),
            .rise (rise[k])
        );
    end
endmodule

// File: tb/tb_io_hub.sv
module tb_io_hub;
    localparam int NK  = 2;
    localparam int SWW = 24;
    localparam int LW  = 24;
    localparam int DB  = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           io_sel = 1'b0, io_read = 1'b0, io_write = 1'b0;
    logic [3:0]     addr = '0;
    logic [15:0]    wdata = '0;
    wire  [15:0]    rdata;
    logic [SWW-1:0] switches = '0;
    logic [NK-1:0]  keys = '0;
    wire  [LW-1:0]  leds;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    string       name_q[$];

    // Reference model: pins reach the debouncer after two sampled edges.
    // A level is accepted once the synced value has disagreed with it for
    // DB consecutive edges.
    logic [LW-1:0]  m_leds;
    logic [SWW-1:0] m_sw_d1, m_sw_d2;
    logic [NK-1:0]  m_k_d1, m_k_d2, m_level, m_flags;
    int             m_run[NK];

    io_hub #(
        .NUM_KEYS(NK), .SW_WIDTH(SWW), .LED_WIDTH(LW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clock), .reset(reset), .io_sel(io_sel), .io_read(io_read),
        .io_write(io_write), .addr(addr), .wdata(wdata), .rdata(rdata),
        .switches(switches), .keys(keys), .leds(leds)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] m_read(input logic [3:0] a);
        logic [31:0] l, s;
        l = 32'(m_leds);
        s = 32'(m_sw_d2);
        case (a[3:1])
            3'd0:    return l[15:0];
            3'd1:    return l[31:16];
            3'd2:    return s[15:0];
            3'd3:    return s[31:16];
            3'd4:    return 16'(m_level);
            3'd5:    return 16'(m_flags);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_edge(input logic r, s, rd, wr, input logic [3:0] a,
                              input logic [15:0] wd, input logic [SWW-1:0] sw,
                              input logic [NK-1:0] k);
        logic [NK-1:0] rs;
        rs = '0;
        if (r) begin
            m_leds = '0; m_sw_d1 = '0; m_sw_d2 = '0;
            m_k_d1 = '0; m_k_d2 = '0; m_level = '0; m_flags = '0;
            for (int i = 0; i < NK; i++) m_run[i] = 0;
            return;
        end
        for (int i = 0; i < NK; i++) begin
            if (m_k_d2[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_level[i] = m_k_d2[i];
                    m_run[i]   = 0;
                    rs[i]      = m_k_d2[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (s && rd && a[3:1] == 3'd5) m_flags = '0;
        m_flags = m_flags | rs;
        if (s && wr) begin
            if (a[3:1] == 3'd0)      m_leds[15:0]    = wd;
            else if (a[3:1] == 3'd1) m_leds[LW-1:16] = wd[LW-17:0];
        end
        m_sw_d2 = m_sw_d1; m_sw_d1 = sw;
        m_k_d2  = m_k_d1;  m_k_d1  = k;
    endtask

    // One clock: the model sees the inputs that were present before the edge.
    task automatic cycle();
        logic r, s, rd, wr;
        logic [3:0] a;
        logic [15:0] wd;
        logic [SWW-1:0] sw;
        logic [NK-1:0] k;
        r = reset; s = io_sel; rd = io_read; wr = io_write;
        a = addr; wd = wdata; sw = switches; k = keys;
        @(posedge clock);
        model_edge(r, s, rd, wr, a, wd, sw, k);
        #1;
    endtask

    task automatic push_exp(input string n, input logic [15:0] e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic rd_c(input logic [3:0] a, input string n, input logic [15:0] e);
        io_sel = 1'b1; io_read = 1'b1; addr = a;
        push_exp(n, e);
        cycle();
        io_sel = 1'b0; io_read = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        io_sel = 1'b1; io_write = 1'b1; addr = a; wdata = d;
        cycle();
        io_sel = 1'b0; io_write = 1'b0;
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic monitor_check();
        logic [15:0] e;
        string n;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rdata_unexpected got=%h exp=none", rdata);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (rdata !== e) begin
                failures++;
                $display("FAIL %s addr=%h got=%h exp=%h", n, addr, rdata, e);
            end
        end
    endtask

    always @(negedge clock) if (io_read) monitor_check();

    initial begin
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Reset during a debounce in progress
        chk("reset_leds", 32'(leds), 32'h0);
        keys = 2'b01;
        repeat (5) cycle();
        reset = 1'b1; keys = 2'b00;
        rd_c(4'h8, "rd_in_reset", 16'h0);
        cycle();
        reset = 1'b0;
        repeat (15) cycle();
        rd_c(4'h8, "rst_level", 16'h0);
        rd_c(4'hA, "rst_flag", 16'h0);
        chk("rst_leds_after", 32'(leds), 32'h0);

        // LED writes
        wr(4'h0, 16'hBEEF);
        wr(4'h2, 16'h00A5);
        chk("leds_write", 32'(leds), 32'h00A5BEEF);
        rd_c(4'h2, "led_hi_rd", 16'h00A5);
        rd_c(4'h0, "led_lo_rd", 16'hBEEF);

        // Switches
        switches = 24'h123456;
        repeat (3) cycle();
        rd_c(4'h4, "sw_lo", 16'h3456);
        rd_c(4'h6, "sw_hi", 16'h0012);
        wr(4'h4, 16'hFFFF);
        rd_c(4'h4, "sw_ro", 16'h3456);
        chk("leds_after_ro_wr", 32'(leds), 32'h00A5BEEF);

        // Bouncing key0 never settles long enough
        for (int seg = 0; seg < 10; seg++) begin
            keys[0] = (seg % 2 == 0);
            repeat (3) rd_c(4'h8, "bounce_level", 16'h0);
        end
        rd_c(4'hA, "bounce_flag", 16'h0);

        // Clean press: level after exactly 2 + DB edges
        keys[0] = 1'b1;
        for (int i = 0; i < 12; i++)
            rd_c(4'h8, (i < 10) ? "press_early" : "press_level", (i < 10) ? 16'h0 : 16'h1);

        // Clear-on-read
        rd_c(4'hA, "flag_set", 16'h0001);
        rd_c(4'hA, "flag_cleared", 16'h0000);

        // key1 rises on the same edge as a flag read: set wins
        keys[1] = 1'b1;
        repeat (9) cycle();
        rd_c(4'hA, "clr_race_rd", 16'h0000);
        rd_c(4'hA, "set_wins", 16'h0002);
        rd_c(4'h8, "both_levels", 16'h0003);

        // Unmapped offsets
        rd_c(4'hC, "unmapped_rd", 16'h0);
        wr(4'hE, 16'hFFFF);
        chk("unmapped_wr_leds", 32'(leds), 32'h00A5BEEF);
        rd_c(4'h0, "unmapped_led_lo", 16'hBEEF);

        // Randomised traffic checked against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 11) == 0) keys = NK'($urandom);
            if ($urandom_range(0, 19) == 0) switches = SWW'($urandom);
            io_sel   = ($urandom_range(0, 3) != 0);
            io_read  = 1'($urandom_range(0, 1));
            io_write = ($urandom_range(0, 3) == 0);
            addr     = 4'($urandom);
            wdata    = 16'($urandom);
            if (io_read) push_exp("rand_rd", io_sel ? m_read(addr) : 16'h0);
            cycle();
            chk("rand_leds", 32'(leds), 32'(m_leds));
        end
        io_sel = 1'b0; io_read = 1'b0; io_write = 1'b0;
        cycle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
